// File: rtl/dest_tag_pipe.sv
// Destination-tag pipeline: per-stage (wa, tnew) bookkeeping for E/M/W, D-stage stall and D-stage forward select.
module dest_tag_pipe #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [4:0]             wa_D,
  input  logic [1:0]             tnew_D,
  input  logic [4:0]             rs_D,
  input  logic [4:0]             rt_D,
  input  logic [1:0]             tuse_rs_D,
  input  logic [1:0]             tuse_rt_D,
  output logic                   stall,
  output logic [4:0]             wa_E,
  output logic [4:0]             wa_M,
  output logic [4:0]             wa_W,
  output logic [1:0]             tnew_E,
  output logic [1:0]             tnew_M,
  output logic [1:0]             fwd_rs_D,
  output logic [1:0]             fwd_rt_D,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [4:0]             wa_e_q, wa_e_d;
  logic [4:0]             wa_m_q, wa_m_d;
  logic [4:0]             wa_w_q, wa_w_d;
  logic [1:0]             tnew_e_q, tnew_e_d;
  logic [1:0]             tnew_m_q, tnew_m_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] wa_e,
    input logic [1:0] tn_e,
    input logic [4:0] wa_m,
    input logic [1:0] tn_m
  );
    return (src != '0) &&
           (((src == wa_e) && (tn_e > tuse)) ||
            ((src == wa_m) && (tn_m > tuse)));
  endfunction

  // Youngest matching producer decides; a not-yet-ready match yields 0
  // rather than falling back to an older stage (stall covers it).
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wa_e,
    input logic [1:0] tn_e,
    input logic [4:0] wa_m,
    input logic [1:0] tn_m,
    input logic [4:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (src == '0) begin
      sel = 2'd0;
    end else if (src == wa_e) begin
      sel = (tn_e == '0) ? 2'd1 : 2'd0;
    end else if (src == wa_m) begin
      sel = (tn_m == '0) ? 2'd2 : 2'd0;
    end else if (src == wa_w) begin
      sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    stall = src_hazard(rs_D, tuse_rs_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q) |
            src_hazard(rt_D, tuse_rt_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
    fwd_rs_D = fwd_sel(rs_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_rt_D = fwd_sel(rt_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
  end

  always_comb begin
    wa_w_d      = wa_m_q;
    wa_m_d      = wa_e_q;
    tnew_m_d    = (tnew_e_q == '0) ? '0 : tnew_e_q - 2'd1;
    wa_e_d      = wa_D;
    tnew_e_d    = tnew_D;
    stall_cnt_d = stall_cnt_q;
    if (stall || flush) begin
      wa_e_d   = '0;
      tnew_e_d = '0;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wa_e_q      <= '0;
      wa_m_q      <= '0;
      wa_w_q      <= '0;
      tnew_e_q    <= '0;
      tnew_m_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wa_e_q      <= wa_e_d;
      wa_m_q      <= wa_m_d;
      wa_w_q      <= wa_w_d;
      tnew_e_q    <= tnew_e_d;
      tnew_m_q    <= tnew_m_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wa_E      = wa_e_q;
  assign wa_M      = wa_m_q;
  assign wa_W      = wa_w_q;
  assign tnew_E    = tnew_e_q;
  assign tnew_M    = tnew_m_q;
  assign stall_cnt = stall_cnt_q;

endmodule
